// File: rtl/prince_enc_scheduler.sv
// ============================================================================
// Module      : prince_enc_scheduler
// Description : Valid/ready job sequencer for the masked PRINCE core: load
//               pulse, PRNG enable, done capture, result hold, run watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prince_enc_scheduler #(
    parameter int LOAD_CYCLES = 1,
    parameter int TIMEOUT     = 100,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             core_start,
    input  logic             core_done,
    output logic             prng_en,
    output logic             capture_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             error,
    input  logic             clear_error,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [LOAD_W-1:0] loadCnt;
    logic              acceptJob;
    logic              timeoutHit;
    logic              countEn;

    // Next-state and output decode; capture_en and in_ready(HOLD) are the
    // only input-dependent outputs.
    always_comb begin
        nextState  = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        prng_en    = 1'b0;
        capture_en = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        acceptJob  = 1'b0;
        timeoutHit = 1'b0;
        countEn    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acceptJob = 1'b1;
                    nextState = LOAD;
                end
            end
            LOAD: begin
                core_start = 1'b1;
                prng_en    = 1'b1;
                busy       = 1'b1;
                countEn    = 1'b1;
                if (loadCnt == LOAD_LAST) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                prng_en = 1'b1;
                busy    = 1'b1;
                countEn = 1'b1;
                // done wins over the watchdog on the boundary cycle
                if (core_done) begin
                    capture_en = 1'b1;
                    nextState  = HOLD;
                end else if (cycle_count == TIMEOUT_V) begin
                    timeoutHit = 1'b1;
                    nextState  = IDLE;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        acceptJob = 1'b1;
                        nextState = LOAD;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loadCnt <= '0;
        end else if (acceptJob) begin
            loadCnt <= '0;
        end else if (state == LOAD && loadCnt != LOAD_LAST) begin
            loadCnt <= loadCnt + 1'b1;
        end
    end

    // Counts LOAD+RUN edges of the current job; saturates rather than wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (acceptJob) begin
            cycle_count <= '0;
        end else if (countEn && cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error <= 1'b0;
        end else if (timeoutHit) begin
            error <= 1'b1;
        end else if (clear_error) begin
            error <= 1'b0;
        end
    end

endmodule

`default_nettype wire
